// File: rtl/systolic_sequencer_pkg.sv
// Shared types for the systolic tile sequencer: array scalar word and FSM states.
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

package systolic_sequencer_pkg;

  localparam int unsigned SINGLE_WIDTH  = 8;
  localparam int unsigned SYS_ARRAY_LEN = `SYS_ARRAY_LEN;

  typedef struct packed {
    logic [SINGLE_WIDTH-1:0] data;
    logic                    valid;
  } scalar_t;

  localparam int unsigned SCALAR_W = $bits(scalar_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/systolic_sequencer_skew_line.sv
// Per-lane scalar delay line of DEPTH registers; flush zeroes every stage.
module systolic_sequencer_skew_line
  import systolic_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SCALAR_W-1:0] din,
  output logic [SCALAR_W-1:0] dout
);

  logic [SCALAR_W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_sequencer.sv
// Runs one output tile on the MAC array: clear, feed K skewed slices, flush, drain, done.
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int unsigned LEN     = SYS_ARRAY_LEN,
  parameter int unsigned KW      = 16,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [LEN*SCALAR_W-1:0] op_col,
  input  logic [LEN*SCALAR_W-1:0] op_row,
  output logic                    arr_clear,
  output logic [LEN*SCALAR_W-1:0] arr_column,
  output logic [LEN*SCALAR_W-1:0] arr_row,
  input  logic                    arr_ready
);

  localparam int unsigned DRAIN_CYC = LEN + MAC_LAT;
  localparam int unsigned CNT_W     = $clog2(DRAIN_CYC + 1);

  seq_state_e       state, state_n;
  logic [KW-1:0]    k_rem, k_rem_n;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_n;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_n;
  logic             abort_c;
  logic             hs_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k_rem     <= '0;
      flush_cnt <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      arr_clear <= 1'b0;
    end else begin
      state     <= state_n;
      k_rem     <= k_rem_n;
      flush_cnt <= flush_cnt_n;
      drain_cnt <= drain_cnt_n;
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
      arr_clear <= (state_n == ST_CLEAR);
    end
  end

  // Next state; abort overrides every transition including a FEED handshake
  always_comb begin
    state_n     = state;
    k_rem_n     = k_rem;
    flush_cnt_n = '0;
    drain_cnt_n = '0;
    op_ready    = 1'b0;
    abort_c     = abort && (state != ST_IDLE);
    hs_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          k_rem_n = k_len;
          state_n = ST_CLEAR;
        end
      end
      ST_CLEAR: state_n = (k_rem != '0) ? ST_FEED : ST_DRAIN;
      ST_FEED: begin
        op_ready = 1'b1;
        if (op_valid) begin
          k_rem_n = k_rem - KW'(1);
          if (k_rem == KW'(1)) state_n = (LEN > 1) ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == CNT_W'(LEN - 2)) state_n = ST_DRAIN;
        else flush_cnt_n = flush_cnt + CNT_W'(1);
      end
      ST_DRAIN: begin
        if (drain_cnt != CNT_W'(DRAIN_CYC)) drain_cnt_n = drain_cnt + CNT_W'(1);
        else if (arr_ready) state_n = ST_DONE;
        else drain_cnt_n = drain_cnt;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    hs_c = op_ready && op_valid && !abort_c;
    if (abort_c) begin
      state_n     = ST_IDLE;
      k_rem_n     = '0;
      flush_cnt_n = '0;
      drain_cnt_n = '0;
    end
  end

  // Lane i is delayed i+1 cycles; non-handshake cycles inject zero bubbles
  for (genvar i = 0; i < int'(LEN); i++) begin : g_lane
    systolic_sequencer_skew_line #(.DEPTH(i + 1)) u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort_c),
      .din   (hs_c ? op_col[i*SCALAR_W +: SCALAR_W] : '0),
      .dout  (arr_column[i*SCALAR_W +: SCALAR_W])
    );
    systolic_sequencer_skew_line #(.DEPTH(i + 1)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort_c),
      .din   (hs_c ? op_row[i*SCALAR_W +: SCALAR_W] : '0),
      .dout  (arr_row[i*SCALAR_W +: SCALAR_W])
    );
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer against a cycle-timeline reference model.
module tb_systolic_sequencer;

  localparam int unsigned LEN     = 4;
  localparam int unsigned KW      = 16;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned SW      = systolic_sequencer_pkg::SCALAR_W;
  localparam int unsigned VW      = LEN * SW;
  localparam int          HD      = 4096;
  localparam int          NEVER   = 32'h3fff_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          op_valid;
  logic          op_ready;
  logic [VW-1:0] op_col;
  logic [VW-1:0] op_row;
  logic          arr_clear;
  logic [VW-1:0] arr_column;
  logic [VW-1:0] arr_row;
  logic          arr_ready;

  systolic_sequencer #(.LEN(LEN), .KW(KW), .MAC_LAT(MAC_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_col     (op_col),
    .op_row     (op_row),
    .arr_clear  (arr_clear),
    .arr_column (arr_column),
    .arr_row    (arr_row),
    .arr_ready  (arr_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one tile described by its start cycle, length and handshake count
  bit            m_active = 1'b0;
  int            m_t, m_k, m_cnt, m_f, m_done;
  logic [VW-1:0] hist_col [HD];
  logic [VW-1:0] hist_row [HD];
  int            obs_done;
  bit            ones_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return m_active && (m_k > 0) && (cyc >= m_t + 2) && (m_cnt < m_k);
  endfunction

  function automatic int drain_start();
    if (m_k == 0) return m_t + 2;
    if (m_f >= 0) return m_f + int'(LEN);
    return NEVER;
  endfunction

  function automatic logic [VW-1:0] exp_skew(input bit col);
    logic [VW-1:0] v;
    logic [VW-1:0] h;
    v = '0;
    for (int i = 0; i < int'(LEN); i++) begin
      if (cyc - 1 - i >= 0) begin
        h = col ? hist_col[(cyc - 1 - i) % HD] : hist_row[(cyc - 1 - i) % HD];
        v[i*SW +: SW] = h[i*SW +: SW];
      end
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] rnd_slice();
    logic [VW-1:0] v;
    logic [SW-1:0] w;
    for (int i = 0; i < int'(LEN); i++) begin
      w = SW'($urandom);
      if (ones_mode) w = SW'(3);
      v[i*SW +: SW] = w;
    end
    return v;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < HD; i++) begin
      hist_col[i] = '0;
      hist_row[i] = '0;
    end
  endtask

  // Compare this cycle's outputs, drive inputs, advance the model, move to the next cycle
  task automatic step(input bit st, input logic [KW-1:0] kl, input bit ab, input bit ov, input bit ar);
    bit was_active;
    bit aborting;
    bit hs;
    bit e_busy, e_done, e_clear, e_ready;
    e_busy  = m_active && (cyc > m_t);
    e_done  = m_active && (cyc == m_done);
    e_clear = m_active && (cyc == m_t + 1);
    e_ready = exp_ready();
    check("busy", 64'(busy), 64'(e_busy));
    check("done", 64'(done), 64'(e_done));
    check("arr_clear", 64'(arr_clear), 64'(e_clear));
    check("op_ready", 64'(op_ready), 64'(e_ready));
    check("arr_column", 64'(arr_column), 64'(exp_skew(1'b1)));
    check("arr_row", 64'(arr_row), 64'(exp_skew(1'b0)));
    if (done) obs_done = cyc;

    start     = st;
    k_len     = kl;
    abort     = ab;
    op_valid  = ov;
    arr_ready = ar;
    op_col    = rnd_slice();
    op_row    = rnd_slice();

    was_active = m_active;
    aborting   = m_active && (cyc > m_t) && ab;
    hs         = 1'b0;
    if (m_active && !aborting) begin
      if (e_ready && ov) begin
        hs = 1'b1;
        m_cnt++;
        if (m_cnt == m_k) m_f = cyc;
      end
      if (m_done < 0 && cyc >= drain_start() + int'(LEN + MAC_LAT) && ar) m_done = cyc + 1;
    end
    hist_col[cyc % HD] = hs ? op_col : '0;
    hist_row[cyc % HD] = hs ? op_row : '0;
    if (aborting) begin
      m_active = 1'b0;
      for (int j = 0; j <= int'(LEN); j++) begin
        if (cyc - j >= 0) begin
          hist_col[(cyc - j) % HD] = '0;
          hist_row[(cyc - j) % HD] = '0;
        end
      end
    end else if (m_active && cyc == m_done) begin
      m_active = 1'b0;
    end else if (!was_active && st) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_k      = int'(kl);
      m_cnt    = 0;
      m_f      = -1;
      m_done   = -1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_tile(input int k, input int vpct, input int rpct, input int apct,
                          input int stall, input int abort_hs, input int ar_hold, output int lat);
    int  t0;
    int  stall_left;
    int  hold;
    int  budget;
    int  stall_arm;
    bit  ov, ab, ar, will_hs;
    t0         = cyc;
    stall_left = 0;
    stall_arm  = stall;
    hold       = ar_hold;
    budget     = 0;
    obs_done   = -1;
    step(1'b1, KW'(k), 1'b0, 1'b0, 1'b1);
    while (m_active && budget < 400) begin
      ov = ($urandom_range(99) < vpct);
      if (stall_left > 0) begin
        ov = 1'b0;
        stall_left--;
      end
      ab = ($urandom_range(99) < apct);
      if (abort_hs > 0 && exp_ready() && ov && m_cnt == abort_hs - 1) ab = 1'b1;
      ar = ($urandom_range(99) < rpct);
      if (m_done < 0 && cyc >= drain_start() + int'(LEN + MAC_LAT) && hold > 0) begin
        ar = 1'b0;
        hold--;
      end
      will_hs = exp_ready() && ov && !ab;
      step($urandom_range(3) == 0, KW'($urandom_range(0, 9)), ab, ov, ar);
      if (will_hs && m_cnt == 1 && stall_arm > 0) begin
        stall_left = stall_arm;
        stall_arm  = 0;
      end
      budget++;
    end
    check("tile_end", 64'(m_active), 64'(0));
    lat = (obs_done < 0) ? -1 : obs_done - t0;
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    op_col    = '0;
    op_row    = '0;
    arr_ready = 1'b1;
    ones_mode = 1'b1;
    clear_hist();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    run_tile(3, 100, 100, 0, 0, 0, 0, lat);
    check("basic_lat", 64'(lat), 64'(15));
    run_tile(3, 100, 100, 0, 2, 0, 0, lat);
    check("stall_lat", 64'(lat), 64'(17));
    run_tile(0, 100, 100, 0, 0, 0, 0, lat);
    check("zero_lat", 64'(lat), 64'(9));
    run_tile(4, 100, 100, 0, 0, 2, 0, lat);
    check("abort_no_done", 64'(lat), 64'(-1));
    run_tile(3, 100, 100, 0, 0, 0, 0, lat);
    check("after_abort_lat", 64'(lat), 64'(15));
    run_tile(3, 100, 100, 0, 0, 0, 5, lat);
    check("drain_bp_lat", 64'(lat), 64'(20));
    run_tile(8, 100, 100, 0, 0, 0, 0, lat);
    check("k8_lat", 64'(lat), 64'(20));

    // Asynchronous reset mid-FEED
    ones_mode = 1'b0;
    step(1'b1, KW'(6), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_clear", 64'(arr_clear), 64'(0));
    check("rst_op_ready", 64'(op_ready), 64'(0));
    check("rst_arr_column", 64'(arr_column), 64'(0));
    check("rst_arr_row", 64'(arr_row), 64'(0));
    m_active = 1'b0;
    clear_hist();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_tile($urandom_range(0, 6), $urandom_range(40, 100), $urandom_range(30, 100),
               ($urandom_range(3) == 0) ? 4 : 0, 0, 0, 0, lat);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        step(1'b0, '0, $urandom_range(1), 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Controller that runs one output tile on the MAC systolic array. On `start` it pulses the array's accumulator clear, then pulls `k_len` operand slices from an upstream valid/ready source. It skews each slice per lane onto the array's column and row inputs, flushes the skew, waits for the array to drain, and raises `done`. It sits between the operand buffers and the systolic array, and a tile-level scheduler drives it.

## Interface
- `LEN`, default `` `SYS_ARRAY_LEN ``: array edge length, lanes per operand slice.
- `KW`, default 16: width of the inner-dimension count.
- `MAC_LAT`, default 2: MAC pipeline latency in cycles, added to the drain wait.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin tile; sampled in IDLE only
- `k_len`  in  KW  slices to feed; latched on accepted `start`
- `abort`  in  1  synchronous abandon of the current tile
- `busy`  out  1  high from CLEAR through DONE
- `done`  out  1  one-cycle pulse, tile results valid on array `out`
- `op_valid`  in  1  operand slice available
- `op_ready`  out  1  sequencer accepts a slice; high only in FEED
- `op_col`  in  LEN×Scalar  column slice, lane i → array column i
- `op_row`  in  LEN×Scalar  row slice, lane i → array row i
- `arr_clear`  out  1  accumulator clear to every MAC
- `arr_column`  out  LEN×Scalar  skewed column feed (registered)
- `arr_row`  out  LEN×Scalar  skewed row feed (registered)
- `arr_ready`  in  1  array reports no valid data in its shift registers

## Operation
- **States:** IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- **IDLE:** `start`=1 latches `k_len` into `k_rem` and moves to CLEAR. `start` is ignored in every other state.
- **CLEAR:** one cycle with `arr_clear`=1. Go to FEED if `k_rem`≠0, otherwise to DRAIN.
- **FEED:** `op_ready`=1.
  - On handshake (`op_valid`&`op_ready`), lane i of `op_col`/`op_row` enters skew line i and `k_rem` decrements.
  - With no handshake, every lane gets a bubble `{0, valid=0}`. All lanes shift every cycle, so alignment is preserved.
  - Go to FLUSH when the handshake takes `k_rem` from 1 to 0.
- **FLUSH:** inject bubbles for LEN-1 cycles (cycle counter), then go to DRAIN.
- **DRAIN:** count LEN+MAC_LAT cycles. After the count completes, move to DONE in the first cycle with `arr_ready`=1; stay in DRAIN while it is 0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Skew:** lane i output = lane i input delayed by i+1 cycles (lane 0 is just the output register). Scalar valid bits travel with data.
- **Abort:**
  - `abort`=1 in any non-IDLE state forces IDLE next cycle and zeroes all skew stages.
  - No `done` pulse is produced.
  - Abort takes priority over every other transition, including a FEED handshake in the same cycle; that slice is dropped.
- **Reset:** asynchronous, to IDLE from any state. Reset values: `busy`=0, `done`=0, `arr_clear`=0, `op_ready`=0, all skew stages and `arr_column`/`arr_row` = `{0, valid=0}`, `k_rem`=0.

## Timing
- **Start accepted at cycle T:** CLEAR at T+1, first FEED cycle T+2.
- **Skew latency:** slice handshaken at cycle t appears on lane i at t+1+i.
- **Back-to-back operands (`op_valid` held 1):**
  - FEED occupies T+2..T+1+K.
  - FLUSH occupies T+2+K..T+K+LEN.
  - Minimum DRAIN is LEN+MAC_LAT cycles.
  - Earliest `done` = T+2+K+2·LEN+MAC_LAT. With LEN=4, MAC_LAT=2, K=8 this is T+20.
- Each stalled FEED cycle delays `done` by exactly one cycle.
- `op_ready` is combinational from state. The other outputs are registered.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that IDLE cycle at the earliest.

## Structure
- **Types package:** holds `Scalar` (`{data[SINGLE_WIDTH], valid}`), `SINGLE_WIDTH`, `SYS_ARRAY_LEN`, and a new `seq_state_e` enum for the six states.
- **`skew_line` sub-module:** per-lane Scalar delay line, parameter DEPTH, with `flush` (synchronous zero) and async reset. Instantiated 2·LEN times from a generate loop: DEPTH=i+1 per column lane and per row lane.
- **Sequencer body:** FSM plus three counters: `k_rem`, FLUSH count, DRAIN count.

## Test plan
- **Basic tile:** LEN=4, MAC_LAT=2, K=3, `op_valid` held 1, all-ones operands, start at cycle 0. Expect `arr_clear` only at cycle 1, `op_ready` high cycles 2–4, `done` at cycle 15, and every array `out` = 3.0.
- **Stall:** same as basic, but drop `op_valid` for 2 cycles after the first handshake. Expect lane-3 valid words exactly 4 cycles after their handshake, bubbles aligned across lanes, `done` at cycle 17, identical results.
- **Zero length:** `start` with `k_len`=0. Expect CLEAR, no `op_ready`, `done` after LEN+MAC_LAT drain cycles with `arr_ready`=1, all outputs 0.
- **Abort:** assert `abort` together with the second FEED handshake. Expect IDLE next cycle, no `done`, skew outputs invalid the same cycle after abort, and the following tile computing correctly after a fresh `clear`.
- **Drain backpressure:** force `arr_ready`=0 for 5 extra cycles past the DRAIN count. Expect `done` delayed exactly 5 cycles and still a single-cycle pulse.
- **Reset and ignored start:** pulse `rst_n` low mid-FEED. Expect all outputs at reset values immediately. Separately, a `start` asserted while `busy`=1 must not alter `k_rem` or the state.
